// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: definitions shared by the execute-stage ALU and the ALU
// control unit.
//   - ALU_* : 3-bit ALUControl encodings
//   - occ_state_e : occupancy states of the execute-stage skid buffer
//   - alu_code_legal() : true for the five supported ALUControl codes
package mips_alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  function automatic logic alu_code_legal(input logic [2:0] code);
    return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
           (code == ALU_SUB) || (code == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Ports:
//   alu_control [2:0]   ALUControl code
//   src_a, src_b        operands (DATA_W bits)
//   result              operation result, modulo 2^DATA_W
//   zero                result == 0
//   overflow            signed overflow, ADD/SUB only
//   illegal_op          alu_control is not a supported code
module alu_core
  import mips_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal_op
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              lt;
  logic              sa, sb;

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;
  assign sa   = src_a[DATA_W-1];
  assign sb   = src_b[DATA_W-1];
  // True signed compare: the sign of diff would be wrong when A-B overflows.
  assign lt   = $signed(src_a) < $signed(src_b);

  always_comb begin
    result     = '0;
    overflow   = 1'b0;
    illegal_op = !alu_code_legal(alu_control);
    case (alu_control)
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_ADD: begin
        result   = sum;
        overflow = (sa == sb) && (sum[DATA_W-1] != sa);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (sa != sb) && (diff[DATA_W-1] != sa);
      end
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU between ID/EX and EX/MEM with a
// 2-entry skid buffer (head + skid) so in_ready is a register.
// Ports:
//   clk, rst (async, active high), flush (sync, drops everything)
//   in_valid / in_ready / alu_control / src_a / src_b   upstream side
//   out_valid / out_ready / alu_result / zero / overflow / illegal_op
//                                                       downstream side
// Handshake: a transfer happens on a side exactly when valid && ready are
// both high at a rising clk edge; a producer holds valid and its payload
// until that edge, and outputs never change while out_valid && !out_ready.
// The occupancy state is held in 'state' (occ_state_e) for observation.
module alu_exec_stage
  import mips_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal_op
);

  occ_state_e        state;

  logic [DATA_W-1:0] core_result;
  logic              core_zero, core_overflow, core_illegal;

  logic [DATA_W-1:0] skid_result;
  logic              skid_zero, skid_overflow, skid_illegal;

  logic              in_xfer, out_xfer;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (core_result),
    .zero        (core_zero),
    .overflow    (core_overflow),
    .illegal_op  (core_illegal)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // The head registers drive the outputs directly, so they hold their last
  // value whenever nothing is buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_EMPTY;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b1;
      overflow      <= 1'b0;
      illegal_op    <= 1'b0;
      skid_result   <= '0;
      skid_zero     <= 1'b1;
      skid_overflow <= 1'b0;
      skid_illegal  <= 1'b0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            alu_result <= core_result;
            zero       <= core_zero;
            overflow   <= core_overflow;
            illegal_op <= core_illegal;
            out_valid  <= 1'b1;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            alu_result <= core_result;
            zero       <= core_zero;
            overflow   <= core_overflow;
            illegal_op <= core_illegal;
          end else if (in_xfer) begin
            skid_result   <= core_result;
            skid_zero     <= core_zero;
            skid_overflow <= core_overflow;
            skid_illegal  <= core_illegal;
            in_ready      <= 1'b0;
            state         <= ST_FULL;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            alu_result <= skid_result;
            zero       <= skid_zero;
            overflow   <= skid_overflow;
            illegal_op <= skid_illegal;
            in_ready   <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
  import mips_alu_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 3;  // {illegal_op, overflow, zero, result}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    alu_control = 3'b000;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  alu_result;
  logic          zero, overflow, illegal_op;

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            failures = 0;

  alu_exec_stage #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .zero        (zero),
    .overflow    (overflow),
    .illegal_op  (illegal_op)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack(input logic [W-1:0] r, input logic z,
                                         input logic ov, input logic il);
    return {il, ov, z, r};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check(name, {{(EW-1){1'b0}}, act}, {{(EW-1){1'b0}}, req});
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] ctl, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [EW-1:0] e);
    bit done = 0;
    in_valid = 1'b1; alu_control = ctl; src_a = a; src_b = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: actual=in_ready_low required=accept ctl=%b", ctl);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Compares the head entry every cycle it is valid, so a stall also
  // verifies that the outputs hold the same entry.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: actual=%h required=none",
                 {illegal_op, overflow, zero, alu_result});
      end else begin
        check("head_entry", {illegal_op, overflow, zero, alu_result}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("reset_out_valid", out_valid, 1'b0);
    check1("reset_in_ready", in_ready, 1'b1);
    check("reset_outputs", {illegal_op, overflow, zero, alu_result}, pack(32'h0, 1, 0, 0));
    @(posedge clk); #1;

    // Directed ALU vectors, full throughput.
    out_ready = 1'b1;
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, pack(32'h8000_0000, 0, 1, 0));
    @(negedge clk);
    check1("latency_one_cycle", out_valid, 1'b1);
    @(posedge clk); #1;
    send(ALU_SUB, 32'd5, 32'd5, pack(32'h0, 1, 0, 0));
    send(ALU_SUB, 32'h8000_0000, 32'h1, pack(32'h7FFF_FFFF, 0, 1, 0));
    send(ALU_SUB, 32'h1, 32'h2, pack(32'hFFFF_FFFF, 0, 0, 0));
    send(ALU_ADD, 32'h3, 32'h4, pack(32'h7, 0, 0, 0));
    send(ALU_ADD, 32'h8000_0000, 32'h8000_0000, pack(32'h0, 1, 1, 0));
    send(ALU_SLT, 32'hFFFF_FFFF, 32'h1, pack(32'h1, 0, 0, 0));
    send(ALU_SLT, 32'h1, 32'hFFFF_FFFF, pack(32'h0, 1, 0, 0));
    send(ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, pack(32'h1, 0, 0, 0));
    send(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, pack(32'hF000_F000, 0, 0, 0));
    send(ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, pack(32'hFFF0_FFF0, 0, 0, 0));
    send(3'b100, 32'h1234_5678, 32'h1, pack(32'h0, 1, 0, 1));
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pack(32'h0, 1, 0, 1));
    send(3'b101, 32'h7FFF_FFFF, 32'h1, pack(32'h0, 1, 0, 1));
    idle(3);

    // Backpressure: A and B accepted, C held while FULL.
    out_ready = 1'b0;
    send(ALU_ADD, 32'h1, 32'h2, pack(32'h3, 0, 0, 0));
    send(ALU_OR, 32'h0F, 32'hF0, pack(32'hFF, 0, 0, 0));
    in_valid = 1'b1; alu_control = ALU_SUB; src_a = 32'd10; src_b = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("full_in_ready_low", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(ALU_SUB, 32'd10, 32'd3, pack(32'h7, 0, 0, 0));
    idle(4);

    // Flush while FULL with a simultaneous input: the input is dropped.
    out_ready = 1'b0;
    send(ALU_ADD, 32'h10, 32'h20, pack(32'h30, 0, 0, 0));
    send(ALU_ADD, 32'h11, 32'h22, pack(32'h33, 0, 0, 0));
    flush = 1'b1; in_valid = 1'b1; alu_control = ALU_OR; src_a = 32'hAA; src_b = 32'h55;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check1("flush_out_valid", out_valid, 1'b0);
    check1("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check1("flush_no_ghost", out_valid, 1'b0);
    @(posedge clk); #1;
    send(ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, pack(32'h0F0F_0000, 0, 0, 0));
    idle(3);

    // Asynchronous reset mid-cycle while FULL.
    out_ready = 1'b0;
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h1, pack(32'h8000_0000, 0, 1, 0));
    send(ALU_SUB, 32'h9, 32'h4, pack(32'h5, 0, 0, 0));
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check1("async_rst_out_valid", out_valid, 1'b0);
    check1("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_outputs", {illegal_op, overflow, zero, alu_result}, pack(32'h0, 1, 0, 0));
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    check1("post_rst_empty", out_valid, 1'b0);
    @(posedge clk); #1;
    send(ALU_OR, 32'h1, 32'h2, pack(32'h3, 0, 0, 0));

    // Drain with a bound.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    check("queue_drained", EW'(exp_q.size()), EW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
